// File: rtl/rv32ima_pkg.sv
// Shared types for the rv32ima memory path: word width, RAM handshake
// states and the RAM arbiter's state/owner encodings.
package rv32ima_pkg;

  localparam int BIT_WIDTH = 32;

  typedef logic [BIT_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    RAM_FREE,
    RAM_ADDR,
    RAM_DATA,
    RAM_ERROR
  } ram_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IBUSY,
    ARB_DBUSY,
    ARB_ERROR
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  function automatic logic arb_busy(arb_state_t s);
    return (s == ARB_IBUSY) || (s == ARB_DBUSY);
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select between fetch (I) and data (D) requesters.
// Ports: ireq_i, dreq_i, last_owner_i in; win_o out (valid when any req).
// Macro RAM_ARB_RR_EN: alternate on collisions instead of D-over-I.
module ram_arb_pick
  import rv32ima_pkg::*;
(
  input  logic       ireq_i,
  input  logic       dreq_i,
  input  arb_owner_t last_owner_i,
  output arb_owner_t win_o
);

`ifdef RAM_ARB_RR_EN
  always_comb begin
    win_o = OWN_D;
    if (ireq_i && dreq_i) begin
      win_o = (last_owner_i == OWN_D) ? OWN_I : OWN_D;
    end else if (ireq_i) begin
      win_o = OWN_I;
    end
  end
`else
  logic unused_owner;

  assign unused_owner = last_owner_i;
  assign win_o = (dreq_i || !ireq_i) ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between fetch (I) and data (D); latches the winner.
// Ports: I/D request+addr in, load/valid/wait out; ram_* to RAM; arb_err.
// Macro RAM_ARB_RR_EN: round-robin on simultaneous requests.
module ram_arbiter
  import rv32ima_pkg::*;
(
  input  logic       ram_clk,
  input  logic       nrst,
  input  logic       iren,
  input  word_t      iaddr,
  output word_t      iload,
  output logic       ivalid,
  output logic       iwait,
  input  logic       dren,
  input  logic       dwen,
  input  word_t      daddr,
  input  logic [1:0] dwidth,
  input  word_t      dstore,
  output word_t      dload,
  output logic       dvalid,
  output logic       dwait,
  output word_t      ram_addr,
  output logic       ram_ren,
  output logic       ram_wen,
  output logic [1:0] ram_width,
  output word_t      ram_store,
  input  word_t      ram_load,
  input  ram_state_t ram_state,
  output logic       arb_err
);

  arb_state_t state_q, state_d;
  arb_owner_t last_q, last_d;
  word_t      addr_q, addr_d;
  word_t      store_q, store_d;
  logic [1:0] width_q, width_d;
  logic       ren_q, ren_d;
  logic       wen_q, wen_d;

  logic       ireq, dreq, busy;
  arb_owner_t win;

  assign ireq = iren;
  assign dreq = dren || dwen;

  ram_arb_pick u_pick (
    .ireq_i       (ireq),
    .dreq_i       (dreq),
    .last_owner_i (last_q),
    .win_o        (win)
  );

  always_ff @(posedge ram_clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ARB_IDLE;
      last_q  <= OWN_I;
      addr_q  <= '0;
      store_q <= '0;
      width_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      width_q <= width_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    store_d = store_q;
    width_d = width_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    if (ram_state == RAM_ERROR) begin
      state_d = ARB_ERROR;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (ireq || dreq) begin
            last_d = win;
            if (win == OWN_D) begin
              state_d = ARB_DBUSY;
              addr_d  = daddr;
              store_d = dstore;
              width_d = dwidth;
              ren_d   = dren;
              wen_d   = dwen;
            end else begin
              state_d = ARB_IBUSY;
              addr_d  = iaddr;
              store_d = '0;
              width_d = WIDTH_WORD;
              ren_d   = 1'b1;
              wen_d   = 1'b0;
            end
          end
        end
        ARB_IBUSY, ARB_DBUSY: begin
          if (ram_state == RAM_DATA) state_d = ARB_IDLE;
        end
        default: state_d = ARB_ERROR;
      endcase
    end
  end

  // Strobes are not gated by the requests: an abandoned access still
  // completes and reports to its owner.
  assign busy      = arb_busy(state_q);
  assign ram_ren   = busy && ren_q;
  assign ram_wen   = busy && wen_q;
  assign ram_addr  = addr_q;
  assign ram_width = width_q;
  assign ram_store = store_q;

  assign ivalid  = (state_q == ARB_IBUSY) && (ram_state == RAM_DATA);
  assign dvalid  = (state_q == ARB_DBUSY) && (ram_state == RAM_DATA);
  assign iwait   = iren && !ivalid;
  assign dwait   = dreq && !dvalid;
  assign iload   = ram_load;
  assign dload   = ram_load;
  assign arb_err = (state_q == ARB_ERROR);

endmodule
